cbd_ibytes_feeder: RTL
======================

# cbd_ibytes_feeder

Burst buffer and transmitter that feeds the CBD sampler with its 64-bit input-byte stream. It accepts PRF/XOF output lanes from upstream under valid/ready, collects exactly one polynomial's worth of lanes (16 for eta=2, 24 for eta=3), and then streams them to the sampler. The sampler consumes one lane per cycle once it starts and never stalls, so the stream must have no gaps. After the last lane, the block waits for the sampler's done pulse and reports completion to the sequencer.

## Interface
Parameters:
- DW, 64: lane width in bits; fixed by the sampler input.
- START_TH, 24: occupancy in words at which streaming begins. Legal range 1..24. The effective threshold is min(START_TH, N).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset. One clock; reset is asynchronous and active-low.
- i_start  in  1  one-cycle request to begin one polynomial burst. Sampled only in S_IDLE.
- i_eta  in  2  noise parameter. Sampled with i_start; only 2 or 3 is legal.
- i_lane  in  DW  upstream lane data.
- i_lane_valid  in  1  upstream data valid.
- o_lane_ready  out  1  upstream accept. A lane transfers when i_lane_valid && o_lane_ready.
- o_ibytes  out  DW  lane presented to the sampler.
- o_ibytes_valid  out  1  sampler data valid.
- i_ibytes_ready  in  1  sampler accept. A pop occurs when o_ibytes_valid && i_ibytes_ready.
- o_eta  out  2  latched eta, driven to the sampler.
- i_cbd_done  in  1  sampler done pulse.
- o_busy  out  1  high in every state except S_IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky underrun flag. Present only with CBD_FEED_UNDERRUN_CHK_EN.

## Operation
- N = 16 when eta=2, 24 when eta=3.
- Buffer: 24 x DW linear register file.
  - Write index wr_cnt (5 bits) and read index rd_cnt (5 bits); both clear on an accepted start.
  - Occupancy = wr_cnt - rd_cnt. The buffer does not wrap within a burst.
- Lanes pass through unmodified and in arrival order. Bit reversal is done inside the sampler.
- FSM states:
  - S_IDLE: on i_start && (i_eta==2 || i_eta==3), latch o_eta, clear counters, go to S_FILL. Any other i_eta: stay in S_IDLE with no side effects.
  - S_FILL: o_lane_ready = (wr_cnt < N). When occupancy >= effective threshold, go to S_STREAM.
  - S_STREAM: keep accepting while wr_cnt < N. o_ibytes = buf[rd_cnt]. o_ibytes_valid = (rd_cnt < N) && (occupancy > 0). When the pop of word N-1 occurs, go to S_WAIT.
  - S_WAIT: o_lane_ready=0, o_ibytes_valid=0. On i_cbd_done go to S_DONE.
  - S_DONE: o_done=1 for one cycle, then S_IDLE.
- Upstream accept and sampler pop in the same cycle are both honoured; occupancy is unchanged.
- i_start outside S_IDLE is ignored.
- o_ibytes_valid and o_lane_ready must not depend combinationally on i_ibytes_ready. The sampler's ready is a function of valid, so such a dependency would form a loop.

## Timing
- Reset values: o_lane_ready=0, o_ibytes_valid=0, o_ibytes=0, o_eta=0, o_busy=0, o_done=0, o_err=0. State returns to S_IDLE and counters clear.
- Reset asserted mid-burst discards all buffered data. There is no partial-burst recovery.
- The first lane can be accepted in the cycle after i_start.
- With a continuous upstream and START_TH=24, eta=3:
  - Accepts occur on cycles 1..24 after start.
  - o_ibytes_valid rises on cycle 25.
  - Pops occur on cycles 25..48.
- o_ibytes and o_ibytes_valid are driven from registers and counters. There is no combinational path from i_lane.
- o_done asserts exactly one cycle after i_cbd_done is seen in S_WAIT.

## Configuration
- CBD_FEED_UNDERRUN_CHK_EN defined:
  - In S_STREAM, a cycle with rd_cnt > 0, rd_cnt < N and occupancy == 0 sets o_err.
  - o_err is sticky until reset or until the next accepted i_start.
  - Its purpose is to catch a START_TH set too low for the upstream rate.
- Undefined: o_err is tied to 0 and no detector logic is built.

## Structure
- Shared package holds:
  - State encodings S_IDLE..S_DONE.
  - N_ETA2=16, N_ETA3=24, BUF_DEPTH=24.
- Sub-module: cbd_feed_buf, a 24 x DW register file with one write and one read port and an asynchronous read. It has no reset on the data array.

## Test plan
- eta=2, continuous lanes 0x0..0x0F, START_TH=24: 16 accepts; o_ibytes emits 0x0..0x0F on consecutive cycles; i_cbd_done -> o_done 1 cycle later; o_busy then 0.
- eta=3, upstream valid every other cycle: exactly 24 accepts; stream starts only after the 24th; 24 gap-free pops in order; o_lane_ready=0 after the 24th accept.
- START_TH=4, eta=3, upstream stalls 10 cycles after lane 6, macro on: o_err=1; the next i_start clears it. Same stimulus with the macro off: o_err stays 0.
- i_start with i_eta=1: o_busy stays 0 and o_lane_ready stays 0. A second i_start during S_STREAM: no effect on counters.
- Async reset asserted after 10 pops of an eta=3 burst: all outputs at reset values immediately. A fresh eta=2 burst then completes correctly.
- Simultaneous accept and pop (START_TH=1): occupancy holds; lane order preserved end to end.

Source files
------------

// File: rtl/cbd_ibytes_feeder_pkg.sv
// Shared types and constants for the CBD input-byte feeder.
package cbd_ibytes_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int N_ETA2    = 16;
    localparam int N_ETA3    = 24;
    localparam int BUF_DEPTH = 24;
    localparam int CNT_W     = 5;

    // Lanes per polynomial for a latched eta (only 2 and 3 ever get latched).
    function automatic logic [CNT_W-1:0] words_for_eta(input logic [1:0] eta);
        logic [CNT_W-1:0] n;
        if (eta == 2'd3) begin
            n = CNT_W'(N_ETA3);
        end else begin
            n = CNT_W'(N_ETA2);
        end
        return n;
    endfunction

endpackage

// File: rtl/cbd_ibytes_feeder_buf.sv
// cbd_feed_buf: 24 x DW register file, one write port, one asynchronous read port.
module cbd_feed_buf
    import cbd_ibytes_feeder_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [CNT_W-1:0]     i_waddr,
    input  logic [DW-1:0]        i_wdata,
    input  logic [CNT_W-1:0]     i_raddr,
    output logic [DW-1:0]        o_rdata
);

    logic [DW-1:0] r_mem [0:BUF_DEPTH-1];

    // Data array write; contents are undefined until written within a burst.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr < CNT_W'(BUF_DEPTH))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr < CNT_W'(BUF_DEPTH)) ? r_mem[i_raddr] : {DW{1'b0}};

endmodule

// File: rtl/cbd_ibytes_feeder.sv
// Burst buffer feeding the CBD sampler with a gap-free 64-bit lane stream.
// Optional underrun detector: define CBD_FEED_UNDERRUN_CHK_EN.
module cbd_ibytes_feeder
    import cbd_ibytes_feeder_pkg::*;
#(
    parameter int DW       = 64,
    parameter int START_TH = 24
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_start,
    input  logic [1:0]    i_eta,
    input  logic [DW-1:0] i_lane,
    input  logic          i_lane_valid,
    output logic          o_lane_ready,
    output logic [DW-1:0] o_ibytes,
    output logic          o_ibytes_valid,
    input  logic          i_ibytes_ready,
    output logic [1:0]    o_eta,
    input  logic          i_cbd_done,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [CNT_W-1:0] TH_CFG = CNT_W'(START_TH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [1:0]       r_eta;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_th;
    logic [CNT_W-1:0] w_occ;
    logic [CNT_W:0]   w_occ_after;
    logic             w_start_ok;
    logic             w_ready;
    logic             w_valid;
    logic             w_accept;
    logic             w_pop;
    logic             w_last_pop;
    logic [DW-1:0]    w_rdata;

    assign w_n         = words_for_eta(r_eta);
    assign w_th        = (TH_CFG < w_n) ? TH_CFG : w_n;
    assign w_occ       = r_wr_cnt - r_rd_cnt;
    assign w_start_ok  = (r_state == S_IDLE) && i_start && ((i_eta == 2'd2) || (i_eta == 2'd3));

    // Handshake qualifiers depend only on state and counters, never on i_ibytes_ready.
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_FILL: begin
                w_ready = (r_wr_cnt < w_n);
                w_valid = 1'b0;
            end
            S_STREAM: begin
                w_ready = (r_wr_cnt < w_n);
                w_valid = (r_rd_cnt < w_n) && (w_occ != {CNT_W{1'b0}});
            end
            default: begin
                w_ready = 1'b0;
                w_valid = 1'b0;
            end
        endcase
    end

    assign w_accept    = w_ready && i_lane_valid;
    assign w_pop       = w_valid && i_ibytes_ready;
    assign w_last_pop  = w_pop && (r_rd_cnt == (w_n - CNT_W'(1)));
    // Counting this cycle's accept lets streaming start the cycle right after the threshold lane lands.
    assign w_occ_after = {1'b0, w_occ} + {{CNT_W{1'b0}}, w_accept};

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                if (w_occ_after >= {1'b0, w_th}) begin
                    w_state_nxt = S_STREAM;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_STREAM: begin
                if (w_last_pop) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_WAIT: begin
                if (i_cbd_done) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write/read indices and latched eta; an accepted start opens a fresh burst.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_cnt <= {CNT_W{1'b0}};
            r_rd_cnt <= {CNT_W{1'b0}};
            r_eta    <= 2'd0;
        end else if (w_start_ok) begin
            r_wr_cnt <= {CNT_W{1'b0}};
            r_rd_cnt <= {CNT_W{1'b0}};
            r_eta    <= i_eta;
        end else begin
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CBD_FEED_UNDERRUN_CHK_EN
    logic r_err;
    logic w_underrun;

    // Buffer ran dry mid-stream: the start threshold is too low for the upstream rate.
    assign w_underrun = (r_state == S_STREAM) && (r_rd_cnt != {CNT_W{1'b0}}) &&
                        (r_rd_cnt < w_n) && (w_occ == {CNT_W{1'b0}});

    // Sticky underrun flag, cleared only by reset or the next accepted start.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_underrun) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    cbd_feed_buf #(
        .DW (DW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_cnt),
        .i_wdata (i_lane),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_rdata)
    );

    // Gating with valid keeps o_ibytes at zero after reset, before the array holds data.
    assign o_ibytes       = w_valid ? w_rdata : {DW{1'b0}};
    assign o_ibytes_valid = w_valid;
    assign o_lane_ready   = w_ready;
    assign o_eta          = r_eta;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);

endmodule
